// File: rtl/register_rename_map.sv
// Speculative arch-to-phys register map for the rename stage. Seeds and drives
// the downstream free list and supports a one-deep rollback of the last rename.
module register_rename_map #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int PW = $clog2(NUM_PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rename_valid,
  input  logic [AW-1:0] rename_rs1,
  input  logic [AW-1:0] rename_rs2,
  input  logic [AW-1:0] rename_rd,
  input  logic          rename_uses_rd,
  output logic          rename_ready,
  output logic [PW-1:0] phys_rs1,
  output logic [PW-1:0] phys_rs2,
  output logic [PW-1:0] phys_rd,
  output logic [PW-1:0] prev_phys_rd,
  output logic          rename_allocated,
  input  logic          rollback,
  input  logic          retire_valid,
  input  logic [PW-1:0] retire_phys,
  output logic          fl_push,
  output logic          fl_potential_push,
  output logic          fl_pop,
  output logic          fl_rollback,
  output logic [PW-1:0] fl_data_in,
  input  logic          fl_valid,
  input  logic [PW-1:0] fl_data_out
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [PW-1:0] ARCH_BASE = PW'(NUM_ARCH_REGS);
  localparam logic [AW-1:0] K_LAST    = AW'(NUM_ARCH_REGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic          last_valid_q, last_valid_d;
  logic [AW-1:0] last_rd_q, last_rd_d;
  logic [PW-1:0] last_prev_q, last_prev_d;
  logic [PW-1:0] map_q [NUM_ARCH_REGS];

  logic alloc, run, accept, do_rb, init_push, ret_push;

  always_comb begin
    run          = (state_q == S_RUN) & ~rst;
    alloc        = rename_uses_rd & (rename_rd != '0);
    rename_ready = run & ~rollback & (fl_valid | ~alloc);
    accept       = rename_valid & rename_ready;
    do_rb        = run & rollback & last_valid_q;
    init_push    = (state_q == S_INIT) & ~rst;
    ret_push     = run & retire_valid;

    phys_rs1         = map_q[rename_rs1];
    phys_rs2         = map_q[rename_rs2];
    prev_phys_rd     = map_q[rename_rd];
    phys_rd          = fl_data_out;
    rename_allocated = alloc;

    fl_pop            = accept & alloc;
    fl_rollback       = do_rb;
    fl_push           = init_push | ret_push;
    fl_potential_push = fl_push;
    fl_data_in        = init_push ? (PW'(k_q) + ARCH_BASE) : retire_phys;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    last_valid_d = last_valid_q;
    last_rd_d    = last_rd_q;
    last_prev_d  = last_prev_q;
    if (state_q == S_INIT) begin
      k_d = k_q + AW'(1);
      if (k_q == K_LAST) state_d = S_RUN;
    end
    // Rollback and accept are mutually exclusive since rename_ready masks rollback.
    if (do_rb) begin
      last_valid_d = 1'b0;
    end else if (accept) begin
      last_valid_d = alloc;
      if (alloc) begin
        last_rd_d   = rename_rd;
        last_prev_d = prev_phys_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      k_q          <= '0;
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
      last_prev_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
      last_prev_q  <= last_prev_d;
    end
  end

  // Map storage is not reset; INIT rewrites every entry with the identity map.
  always_ff @(posedge clk) begin
    if (init_push)   map_q[k_q]       <= PW'(k_q);
    else if (do_rb)  map_q[last_rd_q] <= last_prev_q;
    else if (fl_pop) map_q[rename_rd] <= fl_data_out;
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_INIT)
      assert (!retire_valid) else $error("retire_valid asserted during INIT");
  end

endmodule

// File: tb/tb_register_rename_map.sv
// Directed bench for register_rename_map with a small free-list FIFO model
// providing fl_valid/fl_data_out.
module tb_register_rename_map;

  logic       clk = 1'b0;
  logic       rst;
  logic       rename_valid, rename_uses_rd, rollback, retire_valid;
  logic [4:0] rename_rs1, rename_rs2, rename_rd;
  logic [5:0] retire_phys;
  logic       rename_ready, rename_allocated;
  logic [5:0] phys_rs1, phys_rs2, phys_rd, prev_phys_rd;
  logic       fl_push, fl_potential_push, fl_pop, fl_rollback;
  logic [5:0] fl_data_in;
  logic       fl_valid;
  logic [5:0] fl_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_rename_map #(.NUM_ARCH_REGS(32), .NUM_PHYS_REGS(64)) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rename_rd(rename_rd), .rename_uses_rd(rename_uses_rd), .rename_ready(rename_ready),
    .phys_rs1(phys_rs1), .phys_rs2(phys_rs2), .phys_rd(phys_rd),
    .prev_phys_rd(prev_phys_rd), .rename_allocated(rename_allocated),
    .rollback(rollback), .retire_valid(retire_valid), .retire_phys(retire_phys),
    .fl_push(fl_push), .fl_potential_push(fl_potential_push), .fl_pop(fl_pop),
    .fl_rollback(fl_rollback), .fl_data_in(fl_data_in),
    .fl_valid(fl_valid), .fl_data_out(fl_data_out)
  );

  // Free-list model: FIFO whose rollback re-exposes the most recently popped entry.
  logic [5:0] mem [32];
  logic [4:0] rp, wp;
  int         cnt;

  assign fl_valid    = (cnt != 0);
  assign fl_data_out = mem[rp];

  always @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= 0;
    end else begin
      if (fl_push) begin
        mem[wp] <= fl_data_in;
        wp      <= wp + 5'd1;
      end
      if (fl_pop)           rp <= rp + 5'd1;
      else if (fl_rollback) rp <= rp - 5'd1;
      cnt <= cnt + int'(fl_push) - int'(fl_pop) + int'(fl_rollback);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rename_valid   = 1'b0;
    rename_uses_rd = 1'b0;
    rename_rs1     = '0;
    rename_rs2     = '0;
    rename_rd      = '0;
    rollback       = 1'b0;
    retire_valid   = 1'b0;
    retire_phys    = '0;
  endtask

  task automatic reset_and_init();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (32) step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();

    // Reset cycle: no free-list activity, not ready
    #2;
    chk("rst_push", fl_push, 0);
    chk("rst_pop", fl_pop, 0);
    chk("rst_rb", fl_rollback, 0);
    chk("rst_ready", rename_ready, 0);

    // INIT pushes 32..63 over 32 cycles
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #2;
      chk("init_push", fl_push, 1);
      chk("init_ppush", fl_potential_push, 1);
      chk("init_data", fl_data_in, 32 + i);
      chk("init_ready", rename_ready, 0);
      step();
    end
    #2;
    chk("ready_c33", rename_ready, 1);
    chk("run_idle_push", fl_push, 0);

    // Rename x5 with rs1=x5: sources see old mapping
    rename_valid = 1'b1; rename_uses_rd = 1'b1; rename_rd = 5'd5; rename_rs1 = 5'd5;
    #2;
    chk("rn_phys_rd", phys_rd, 32);
    chk("rn_prev", prev_phys_rd, 5);
    chk("rn_rs1_old", phys_rs1, 5);
    chk("rn_alloc", rename_allocated, 1);
    chk("rn_pop", fl_pop, 1);
    step();
    rename_uses_rd = 1'b0;
    #2;
    chk("rn_rs1_new", phys_rs1, 32);
    chk("rn_noalloc_pop", fl_pop, 0);
    chk("rn_noalloc_ready", rename_ready, 1);
    step();

    // Rollback of a fresh rename
    reset_and_init();
    rename_valid = 1'b1; rename_uses_rd = 1'b1; rename_rd = 5'd5; rename_rs1 = 5'd5;
    #2;
    chk("rb_rename_rd", phys_rd, 32);
    step();
    rollback = 1'b1; rename_rd = 5'd7;
    #2;
    chk("rb_pulse", fl_rollback, 1);
    chk("rb_ready", rename_ready, 0);
    chk("rb_nopop", fl_pop, 0);
    step();
    rename_valid = 1'b0; rename_rs1 = 5'd5;
    #2;
    chk("rb_second", fl_rollback, 0);
    chk("rb_restored", phys_rs1, 5);
    step();
    rollback = 1'b0; rename_valid = 1'b1; rename_rd = 5'd5;
    #2;
    chk("rb_realloc", phys_rd, 32);
    chk("rb_realloc_prev", prev_phys_rd, 5);
    step();

    // Exhaust free list, stall, x0 passes, retire unblocks
    reset_and_init();
    rename_valid = 1'b1; rename_uses_rd = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rename_rd = 5'((i % 31) + 1);
      #2;
      chk("ex_ready", rename_ready, 1);
      chk("ex_phys_rd", phys_rd, 32 + i);
      step();
    end
    rename_rd = 5'd9;
    #2;
    chk("ex_stall", rename_ready, 0);
    chk("ex_stall_pop", fl_pop, 0);
    step();
    rename_rd = 5'd0;
    #2;
    chk("ex_x0_ready", rename_ready, 1);
    chk("ex_x0_alloc", rename_allocated, 0);
    chk("ex_x0_pop", fl_pop, 0);
    step();
    rename_valid = 1'b0; retire_valid = 1'b1; retire_phys = 6'd7;
    #2;
    chk("ex_ret_push", fl_push, 1);
    chk("ex_ret_data", fl_data_in, 7);
    step();
    retire_valid = 1'b0; rename_valid = 1'b1; rename_rd = 5'd9;
    #2;
    chk("ex_unstall", rename_ready, 1);
    chk("ex_unstall_rd", phys_rd, 7);
    chk("ex_unstall_prev", prev_phys_rd, 40);
    step();

    // Rename and retire in the same cycle
    reset_and_init();
    rename_valid = 1'b1; rename_uses_rd = 1'b1; rename_rd = 5'd3;
    retire_valid = 1'b1; retire_phys = 6'd40;
    #2;
    chk("rr_pop", fl_pop, 1);
    chk("rr_push", fl_push, 1);
    chk("rr_data", fl_data_in, 40);
    chk("rr_phys_rd", phys_rd, 32);
    chk("rr_prev", prev_phys_rd, 3);
    step();
    idle_inputs();
    rename_rs2 = 5'd3;
    #2;
    chk("rr_rs2", phys_rs2, 32);
    step();

    // Reset in the middle of INIT restarts the push sequence
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    #2;
    chk("mid_push_k10", fl_data_in, 42);
    rst = 1'b1;
    #1;
    chk("mid_rst_push", fl_push, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #2;
      chk("mid_push", fl_push, 1);
      chk("mid_data", fl_data_in, 32 + i);
      step();
    end
    #2;
    chk("mid_ready", rename_ready, 1);
    chk("mid_done_push", fl_push, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_rename_map.md
# register_rename_map

Speculative architectural-to-physical register map for the rename stage. It sits directly upstream of `register_free_list` and drives all of that FIFO's control and data inputs:

- It fills the free list with the initially unmapped physical registers after reset.
- It pops a free physical register for each renamed instruction that writes `rd`.
- It pushes freed physical registers back at retire.
- It can undo the single most recent rename (one-deep rollback).

## Interface
Parameters:
- `NUM_ARCH_REGS`, default 32: architectural registers; x0 is never renamed.
- `NUM_PHYS_REGS`, default 64: physical registers; must equal 2×`NUM_ARCH_REGS`. Free-list depth is `NUM_PHYS_REGS-NUM_ARCH_REGS`.

Derived widths: `AW=$clog2(NUM_ARCH_REGS)`, `PW=$clog2(NUM_PHYS_REGS)`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rename_valid`  in  1  instruction presented for rename
- `rename_rs1`, `rename_rs2`  in  AW each  source architectural registers
- `rename_rd`  in  AW  destination architectural register
- `rename_uses_rd`  in  1  instruction writes `rd`
- `rename_ready`  out  1  rename accepted this cycle when high with `rename_valid`
- `phys_rs1`, `phys_rs2`  out  PW each  current mappings of the sources
- `phys_rd`  out  PW  newly allocated physical register
- `prev_phys_rd`  out  PW  mapping of `rd` before this rename, carried to retire
- `rename_allocated`  out  1  this rename popped the free list
- `rollback`  in  1  undo the most recent accepted rename
- `retire_valid`  in  1  retiring instruction frees a register
- `retire_phys`  in  PW  physical register to free (the instruction's `prev_phys_rd`)
- `fl_push`, `fl_potential_push`, `fl_pop`, `fl_rollback`  out  1 each  free-list controls
- `fl_data_in`  out  PW  free-list write data
- `fl_valid`  in  1  free list has an entry
- `fl_data_out`  in  PW  head of the free list

## Operation
State machine:
- `INIT` is the state entered on reset.
  - Counter `k` runs 0..`NUM_ARCH_REGS-1`, one step per cycle.
  - Each cycle writes `table[k]<=k`.
  - Each cycle drives `fl_push=fl_potential_push=1` with `fl_data_in=k+NUM_ARCH_REGS`.
  - When `k=NUM_ARCH_REGS-1`, the block goes to `RUN`.
- `RUN` is the only other state. It is left only on `rst`.

Rename (RUN only):
- `alloc = rename_uses_rd & (rename_rd!=0)`.
- `rename_ready = RUN & ~rollback & (fl_valid | ~alloc)`.
- `phys_rs1=table[rename_rs1]` and `phys_rs2=table[rename_rs2]`. Both read the pre-update table, so when `rd` equals `rs1` or `rs2` the source sees the old mapping.
- `phys_rd=fl_data_out`. `prev_phys_rd=table[rename_rd]`. `rename_allocated=alloc`.
- On accept (`rename_valid & rename_ready`) with `alloc`:
  - `fl_pop=1`.
  - `table[rename_rd]<=fl_data_out`.
  - Record `last_rd`, `last_prev` and `last_valid<=1`.
- On accept with `~alloc`: `last_valid<=0`. There is no pop and no table write.
- `table[0]` always holds 0.

Rollback:
- If `rollback & last_valid`: `table[last_rd]<=last_prev`, `fl_rollback=1` for exactly that cycle, and `last_valid<=0`.
- If `rollback & ~last_valid`: no effect, and `fl_rollback` stays 0.
- A rename is never accepted in a rollback cycle.

Retire:
- `retire_valid` in RUN drives `fl_push=fl_potential_push=1` with `fl_data_in=retire_phys`.
- A retire and a rename pop in the same cycle are legal and both take effect.
- `retire_valid` in INIT is a protocol violation and is covered by an assertion.

## Timing
- Reset values:
  - State `INIT` and `k=0`.
  - `last_valid=0`.
  - `rename_ready=0`.
  - All `fl_*` controls 0 during the reset cycle.
  - Table contents are undefined until INIT completes.
- INIT lasts exactly `NUM_ARCH_REGS` cycles after reset deasserts. `rename_ready` first rises in the following cycle, provided `rollback=0`.
- Rename outputs are combinational in the acceptance cycle. The table update is visible from the next cycle.
- Rollback applies to the rename accepted in an earlier cycle. Its table restore is visible the cycle after `rollback`.
- Free list empty (`fl_valid=0`): an allocating rename stalls with `rename_ready=0`. A non-allocating rename still proceeds.
- `rst` asserted mid-INIT or mid-RUN restarts INIT with `k=0`. The free-list FIFO is reset by the same `rst`.

## Test plan
- Reset, then idle → 32 pushes carrying data 32..63, and `rename_ready` rises in cycle 33.
- Rename x5 (`uses_rd`) after init, with `rs1=5` → `phys_rd=32`, `prev_phys_rd=5`, `phys_rs1=5`; the next rename with `rs1=5` reads 32.
- Rename x5, then assert `rollback` → `fl_rollback` pulses once, x5 maps to 5, and a second `rollback` produces no `fl_rollback`.
- Perform 32 allocating renames without any retire → the 33rd allocating rename stalls, a `rd=x0` rename is still accepted, then `retire_valid` with `retire_phys=7` unblocks the stall with `phys_rd=7`.
- Rename x3 with simultaneous retire of 40 → `fl_pop=1` and `fl_push=1` with `fl_data_in=40` in the same cycle.
- Assert `rst` at INIT cycle 10 → the push sequence restarts at 32 and completes all 32 pushes.
